// File: rtl/decoder_scan_seq_pkg.sv
// Shared definitions for the decoder row scanner: FSM encoding and the
// row/select geometry shared with the 3:8 decoder instances.
package decoder_scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int ROWS  = 8;
  localparam int SEL_W = 3;

endpackage

// File: rtl/decoder_scan_seq_next_row.sv
// Circular priority search: first set bit of mask strictly above cur,
// wrapping through bit 0 and back to cur itself.
module decoder_scan_seq_next_row
  import decoder_scan_seq_pkg::*;
(
  input  logic [ROWS-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    // k = ROWS lands back on cur, covering the single-row case
    for (int k = 1; k <= ROWS; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    any  = |mask;
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Row scan sequencer for an active-low 3:8 decoder: walks enabled rows,
// holding each for DWELL_CYC clocks behind a BLANK_CYC all-high gap.
//
// state | meaning
// IDLE  | not scanning, enb_ high, sel holds
// BLANK | enb_ high ahead of driving the row in sel
// DRIVE | enb_ low, row in sel is on for the dwell period
module decoder_scan_seq
  import decoder_scan_seq_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             run,
  input  logic             oneshot,
  input  logic [ROWS-1:0]  row_mask,
  output logic [SEL_W-1:0] sel,
  output logic             enb_,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [DWELL_W-1:0] DWELL_LD  = DWELL_W'(DWELL_CYC - 1);
  localparam logic [DWELL_W-1:0] BLANK_LD  = (BLANK_CYC > 0) ? DWELL_W'(BLANK_CYC - 1) : '0;
  localparam bit                 HAS_BLANK = (BLANK_CYC > 0);

  scan_state_t      state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] nxt;
  logic             wrap;
  logic             any;
  logic             last_drive;

  // Searching above the top row from IDLE yields the lowest enabled row
  assign cur = (state == IDLE) ? SEL_W'(ROWS - 1) : sel;

  decoder_scan_seq_next_row u_next_row (
    .mask (row_mask),
    .cur  (cur),
    .nxt  (nxt),
    .wrap (wrap),
    .any  (any)
  );

  assign last_drive = (state == DRIVE) && (cnt == '0);
  assign busy       = (state != IDLE);
  assign frame_done = last_drive && wrap && any;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
      sel   <= '0;
      enb_  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run && any) begin
            sel <= nxt;
            if (HAS_BLANK) begin
              state <= BLANK;
              cnt   <= BLANK_LD;
            end else begin
              state <= DRIVE;
              cnt   <= DWELL_LD;
              enb_  <= 1'b0;
            end
          end
        end
        BLANK: begin
          if (!run) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= DRIVE;
            cnt   <= DWELL_LD;
            enb_  <= 1'b0;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (!run || !any || (wrap && oneshot)) begin
            state <= IDLE;
            enb_  <= 1'b1;
          end else begin
            sel <= nxt;
            if (HAS_BLANK) begin
              state <= BLANK;
              cnt   <= BLANK_LD;
              enb_  <= 1'b1;
            end else begin
              cnt <= DWELL_LD;
            end
          end
        end
        default: begin
          state <= IDLE;
          enb_  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: one build with a 1-clock blank gap and one
// without, both compared every cycle against a row-walk reference model.
module tb_decoder_scan_seq;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       run = 1'b0;
  logic       oneshot = 1'b0;
  logic [7:0] row_mask = 8'h00;

  logic [2:0] sel0, sel1;
  logic       enb0, enb1, busy0, busy1, fd0, fd1;

  int total = 0;
  int bad = 0;
  int cycn = 0;
  int last_fd = -1;
  bit chk_period = 1'b0;

  // model: per build, whether scanning, whether driving, current row and
  // clocks left in the current phase (including the present one)
  bit m_act [2];
  bit m_drv [2];
  int m_row [2];
  int m_left[2];
  int blank_of[2];

  always #5 clk = ~clk;

  decoder_scan_seq #(.DWELL_W(16), .DWELL_CYC(DWELL), .BLANK_CYC(1)) dut0 (
    .clk(clk), .rst_(rst_), .run(run), .oneshot(oneshot), .row_mask(row_mask),
    .sel(sel0), .enb_(enb0), .busy(busy0), .frame_done(fd0));

  decoder_scan_seq #(.DWELL_W(16), .DWELL_CYC(DWELL), .BLANK_CYC(0)) dut1 (
    .clk(clk), .rst_(rst_), .run(run), .oneshot(oneshot), .row_mask(row_mask),
    .sel(sel1), .enb_(enb1), .busy(busy1), .frame_done(fd1));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cycn, got, exp);
    end
  endtask

  function automatic int next_row(input int row, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) begin
      int r;
      r = (row + k) % 8;
      if (m[r]) return r;
    end
    return row;
  endfunction

  function automatic int low_row(input logic [7:0] m);
    for (int r = 0; r < 8; r++)
      if (m[r]) return r;
    return 0;
  endfunction

  task automatic begin_row(input int i);
    if (blank_of[i] > 0) begin
      m_drv[i]  = 1'b0;
      m_left[i] = blank_of[i];
    end else begin
      m_drv[i]  = 1'b1;
      m_left[i] = DWELL;
    end
  endtask

  task automatic step(input int i);
    if (!rst_) begin
      m_act[i] = 1'b0; m_drv[i] = 1'b0; m_row[i] = 0; m_left[i] = 0;
    end else if (!m_act[i]) begin
      if (run && row_mask != 0) begin
        m_act[i] = 1'b1;
        m_row[i] = low_row(row_mask);
        begin_row(i);
      end
    end else if (!m_drv[i]) begin
      if (!run) m_act[i] = 1'b0;
      else if (m_left[i] == 1) begin
        m_drv[i] = 1'b1; m_left[i] = DWELL;
      end else m_left[i]--;
    end else if (m_left[i] > 1) begin
      m_left[i]--;
    end else begin
      int nx;
      bit wrap;
      nx   = next_row(m_row[i], row_mask);
      wrap = (nx <= m_row[i]);
      if (!run || row_mask == 0 || (wrap && oneshot)) begin
        m_act[i] = 1'b0; m_drv[i] = 1'b0;
      end else begin
        m_row[i] = nx;
        begin_row(i);
      end
    end
  endtask

  function automatic int exp_fd(input int i);
    return (m_act[i] && m_drv[i] && m_left[i] == 1 && row_mask != 0 &&
            next_row(m_row[i], row_mask) <= m_row[i]) ? 1 : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    chk("sel0",  int'(sel0),  m_row[0]);
    chk("enb0",  int'(enb0),  (m_act[0] && m_drv[0]) ? 0 : 1);
    chk("busy0", int'(busy0), m_act[0] ? 1 : 0);
    chk("fd0",   int'(fd0),   exp_fd(0));
    chk("sel1",  int'(sel1),  m_row[1]);
    chk("enb1",  int'(enb1),  (m_act[1] && m_drv[1]) ? 0 : 1);
    chk("busy1", int'(busy1), m_act[1] ? 1 : 0);
    chk("fd1",   int'(fd1),   exp_fd(1));
    if (chk_period && fd0) begin
      if (last_fd >= 0) chk("period0", cycn - last_fd, 8 * (DWELL + 1));
      last_fd = cycn;
    end
    cycn++;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    blank_of[0] = 1;
    blank_of[1] = 0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_drv[i] = 1'b0; m_row[i] = 0; m_left[i] = 0;
    end

    cycles(3);
    rst_ = 1'b1;
    cycles(2);

    // full mask, frame period check
    row_mask = 8'hFF; run = 1'b1;
    chk_period = 1'b1; last_fd = -1;
    cycles(100);
    chk_period = 1'b0;

    // reset held for 2 clocks while driving row 3 of the blanked build
    rst_ = 1'b0; run = 1'b0; cycles(3);
    rst_ = 1'b1; run = 1'b1; row_mask = 8'hFF;
    cycles(17);
    rst_ = 1'b0; cycles(2);
    rst_ = 1'b1; run = 1'b0; cycles(3);

    // sparse mask, then narrowed mid-frame
    row_mask = 8'b1010_0100; run = 1'b1;
    cycles(33);
    row_mask = 8'h01;
    cycles(15);

    // single oneshot frame
    run = 1'b0; cycles(6);
    oneshot = 1'b1; row_mask = 8'h01; run = 1'b1;
    cycles(5);
    run = 1'b0; cycles(4);
    oneshot = 1'b0;

    // run dropped mid-drive and during blank
    row_mask = 8'hFF; run = 1'b1; cycles(18);
    run = 1'b0; cycles(6);
    run = 1'b1; cycles(6);
    run = 1'b0; cycles(4);

    // empty mask keeps both idle; two-row mask for the gapless build
    run = 1'b1; row_mask = 8'h00; cycles(10);
    row_mask = 8'h03; cycles(30);

    // randomized operation
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 9) == 0) row_mask = 8'h00;
        else row_mask = 8'($urandom_range(1, 255));
      end
      rst_ = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
